dimmer_button_sequencer: RTL

DIMMER_BUTTON_SEQUENCER -- requirements
Module: dimmer_button_sequencer

---
 rtl/dimmer_pkg.sv | 29 ++
 rtl/button_debouncer.sv | 50 +++++
 rtl/dimmer_button_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/dimmer_pkg.sv
// Shared definitions for the dimmer button sequencer: FSM state encoding,
// default timing constants and a small sizing helper.
package dimmer_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_COMBO = 3'd1,
    HELD_UP    = 3'd2,
    HELD_DOWN  = 3'd3,
    HELD_BOTH  = 3'd4
  } dimmer_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000;
  localparam int unsigned DEF_COMBO_WINDOW    = 250;
  localparam int unsigned DEF_REPEAT_DELAY    = 5000;
  localparam int unsigned DEF_REPEAT_RATE     = 1000;

  // Largest of four values, used to size the shared timing counters.
  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer followed by a counting debouncer. The output level
// only follows the synchronized input after it has disagreed with the
// current level for DEBOUNCE_CYCLES consecutive cycles.
module button_debouncer
  import dimmer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_level
);

  localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] stable_cnt;

  // Bring the raw asynchronous button into the clock domain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= i_btn;
      sync_q2 <= sync_q1;
    end
  end

  // Count consecutive disagreeing cycles; any agreement restarts the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stable_cnt <= '0;
      o_level    <= 1'b0;
    end else if (sync_q2 != o_level) begin
      if (stable_cnt == CNT_LAST) begin
        o_level    <= sync_q2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end else begin
      stable_cnt <= '0;
    end
  end

endmodule

// File: rtl/dimmer_button_sequencer.sv
// Turns two raw dimmer buttons into one-cycle up/down/OFF command pulses,
// with a combo window for "both pressed" and auto-repeat while held.
module dimmer_button_sequencer
  import dimmer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned COMBO_WINDOW    = DEF_COMBO_WINDOW,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_up,
  input  logic i_btn_down,
  output logic o_up,
  output logic o_down,
  output logic o_held
);

  localparam int unsigned CNT_W =
    $clog2(max4(DEBOUNCE_CYCLES, COMBO_WINDOW, REPEAT_DELAY, REPEAT_RATE) + 1);
  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(COMBO_WINDOW - 1);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);

  dimmer_state_t    state;
  logic             dir_up;
  logic             first_rep;
  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] rep_cnt;

  logic lvl_up, lvl_dn;
  logic lvl_up_q, lvl_dn_q;
  logic press_up, press_dn, rel_up, rel_dn;
  logic press_other, rel_own;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_btn_up),
    .o_level (lvl_up)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_btn_down),
    .o_level (lvl_dn)
  );

  // Delayed copies of the debounced levels for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lvl_up_q <= 1'b0;
      lvl_dn_q <= 1'b0;
    end else begin
      lvl_up_q <= lvl_up;
      lvl_dn_q <= lvl_dn;
    end
  end

  // Press/release events and their meaning relative to the recorded button.
  always_comb begin
    press_up    = lvl_up & ~lvl_up_q;
    press_dn    = lvl_dn & ~lvl_dn_q;
    rel_up      = ~lvl_up & lvl_up_q;
    rel_dn      = ~lvl_dn & lvl_dn_q;
    press_other = dir_up ? press_dn : press_up;
    rel_own     = dir_up ? rel_up : rel_dn;
  end

  // Sequencer FSM with registered command outputs; at most one command per cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      dir_up    <= 1'b0;
      first_rep <= 1'b0;
      win_cnt   <= '0;
      rep_cnt   <= '0;
      o_up      <= 1'b0;
      o_down    <= 1'b0;
      o_held    <= 1'b0;
    end else begin
      o_up   <= 1'b0;
      o_down <= 1'b0;
      case (state)
        IDLE: begin
          o_held <= 1'b0;
          if (press_up && press_dn) begin
            o_up   <= 1'b1;
            o_down <= 1'b1;
            state  <= HELD_BOTH;
          end else if (press_up || press_dn) begin
            dir_up  <= press_up;
            win_cnt <= '0;
            state   <= WAIT_COMBO;
          end
        end

        // Other-press beats release, which beats window expiry.
        WAIT_COMBO: begin
          if (press_other) begin
            o_up   <= 1'b1;
            o_down <= 1'b1;
            state  <= HELD_BOTH;
          end else if (rel_own) begin
            o_up   <= dir_up;
            o_down <= ~dir_up;
            state  <= IDLE;
          end else if (win_cnt == WIN_LAST) begin
            o_up      <= dir_up;
            o_down    <= ~dir_up;
            o_held    <= 1'b1;
            rep_cnt   <= '0;
            first_rep <= 1'b1;
            state     <= dir_up ? HELD_UP : HELD_DOWN;
          end else begin
            win_cnt <= win_cnt + 1'b1;
          end
        end

        // One counter serves both the initial delay and the repeat period,
        // selected by first_rep; it restarts on every repeat pulse.
        HELD_UP, HELD_DOWN: begin
          if (press_other) begin
            o_up   <= 1'b1;
            o_down <= 1'b1;
            o_held <= 1'b0;
            state  <= HELD_BOTH;
          end else if (rel_own) begin
            o_held <= 1'b0;
            state  <= IDLE;
          end else if (rep_cnt == (first_rep ? DLY_LAST : RATE_LAST)) begin
            o_up      <= dir_up;
            o_down    <= ~dir_up;
            rep_cnt   <= '0;
            first_rep <= 1'b0;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
        end

        HELD_BOTH: begin
          o_held <= 1'b0;
          if (!lvl_up && !lvl_dn) state <= IDLE;
        end

        default: begin
          o_held <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
